hram_wb_arbiter: RTL and testbench
==================================

# hram_wb_arbiter

Round-robin Wishbone (classic, single-beat) arbiter that shares the one `wb_hyperram` slave port between N masters, e.g. the picosoc iomem bridge and a DMA/frame reader. It sits between the masters and `wb_hyperram`, and both run on the same clk. It holds a grant for the whole `cyc` of the winning master. A watchdog aborts slave transactions that never acknowledge and answers the stalled master with `err`.

## Interface
Parameters:
- NUM_M, 2: number of masters (2..8).
- AW, 32: address width.
- DW, 32: data width; SW = DW/8 select bits.
- TIMEOUT, 255: cycles from slave `stb` to forced abort (1..65535).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset: synchronous, active-low; clock clk.
- m_cyc_i  in  NUM_M  per-master `cyc`.
- m_stb_i  in  NUM_M  per-master `stb`.
- m_we_i  in  NUM_M  per-master write enable.
- m_sel_i  in  NUM_M*SW  byte selects, master k at [k*SW +: SW].
- m_adr_i  in  NUM_M*AW  addresses, packed the same way.
- m_dat_i  in  NUM_M*DW  write data, packed the same way.
- m_dat_o  out  NUM_M*DW  read data; 0 for non-granted masters.
- m_ack_o  out  NUM_M  acknowledge, granted master only.
- m_err_o  out  NUM_M  timeout error, one-cycle pulse.
- s_cyc_o, s_stb_o, s_we_o  out  1  to `wb_hyperram`.
- s_sel_o  out  SW  to slave.
- s_adr_o  out  AW  to slave.
- s_dat_o  out  DW  to slave.
- s_dat_i  in  DW  from slave.
- s_ack_i  in  1  from slave.
- grant_o  out  NUM_M  one-hot current owner; 0 when idle.
- timeout_o  out  1  one-cycle pulse on each abort.

## Operation
- FSM states: IDLE, OWN, ABORT, GAP.
- IDLE:
  - Requesters are masters with `m_cyc_i` high.
  - If any requester exists, pick the first one strictly after `last` (rotating priority), register its one-hot `grant`, and go to OWN.
  - `last` resets to NUM_M-1, so master 0 wins first.
- OWN:
  - Slave signals mux combinationally from the granted master. `s_cyc_o` is that master's `cyc`; `s_stb_o` is its `cyc & stb`.
  - The slave's `ack` and `dat` route back to the granted master only.
  - Go to GAP and set `last` = owner when the granted master drops `cyc`.
  - Multiple strobes under one `cyc` stay granted, so read-modify-write sequences are atomic.
- Watchdog:
  - Counts cycles in OWN while `s_stb_o & ~s_ack_i`; clears on `ack` or `stb` low.
  - When the count reaches TIMEOUT, go to ABORT.
- ABORT (1 cycle):
  - `s_cyc_o` = `s_stb_o` = 0.
  - `m_err_o` pulses for the owner; `timeout_o` pulses.
  - `last` = owner, then go to GAP.
  - The master is expected to drop `cyc` after `err`. If it keeps `cyc` high, it competes again as a normal requester.
- GAP (1 cycle):
  - Slave `cyc` low for one idle cycle, so `wb_hyperram` sees CS deassert between owners.
  - `grant` clears, then go to IDLE.
- Default outputs: all slave outputs are 0 unless in OWN. Non-granted `m_ack_o`/`m_err_o`/`m_dat_o` are 0.
- Reset: all outputs 0, state IDLE, counter 0, `last` = NUM_M-1. Reset mid-transaction drops `s_cyc_o` in the following cycle; no `ack`/`err` is generated.

## Timing
- Arbitration latency: `cyc` rises in cycle n in IDLE → `grant_o`/`s_cyc_o` high in cycle n+1.
- Pass-through in OWN: combinational, zero added cycles. `s_ack_i` appears on `m_ack_o` in the same cycle.
- Owner switch cost: owner drops `cyc` at cycle n → GAP at n+1 → IDLE at n+2 → next grant at n+3.
- Simultaneous requests: resolved purely by rotation. Under continuous contention no master waits more than NUM_M-1 tenures.
- `ack` and timeout in the same cycle: `ack` wins; no abort.
- Owner drops `cyc` in the same cycle the timeout fires: treated as a normal release (GAP); no `err`.
- Counter width is clog2(TIMEOUT+1) and saturates (no wrap).

## Structure
- Package `hram_arb_pkg`:
  - State enum (IDLE, OWN, ABORT, GAP).
  - Function `rr_pick(req, last)` returning a one-hot vector.
- Sub-module `hram_arb_wdog`: watchdog counter with inputs `start`/`clear` and output `expired`.

## Test plan
- **Single master:** NUM_M=2. M0 reads 0x3000_0010 while the slave acks after 12 cycles with 0xDEADBEEF. Expect `grant_o`=01 one cycle after `cyc`, M0 gets the data with `ack`, and M1 sees `ack`=0 and `dat`=0.
- **Simultaneous requests after reset:** M0 and M1 raise `cyc` in the same cycle. Expect M0 granted first, then GAP, then M1 granted at +3 after M0 releases.
- **Continuous contention:** both masters always requesting for 20 transactions. Expect strict alternation of grants 01,10,01,…; each master gets exactly 10.
- **Atomic tenure:** M0 holds `cyc` across a read then a write (two `stb`s) while M1 is requesting. Expect no grant change until M0 drops `cyc`.
- **Timeout:** TIMEOUT=16 and the slave never acks. Expect `m_err_o[0]` and `timeout_o` pulse exactly 16 cycles after `stb`, `s_cyc_o` low during ABORT and GAP, and M1 served next.
- **Reset mid-transaction:** `resetn` low during an M1 tenure. Expect all outputs 0 the next cycle, and after reset release the first grant goes to M0.

Source files
------------

// File: rtl/hram_arb_pkg.sv
// hram_arb_pkg: shared state encoding and rotating-priority pick for the HyperRAM arbiter.
package hram_arb_pkg;
  localparam int MAX_M = 8;
  typedef enum logic [1:0] {IDLE, OWN, ABORT, GAP} state_t;
  // First requester strictly after last, wrapping at n; one-hot result, 0 if none.
  function automatic logic [MAX_M-1:0] rr_pick(input logic [MAX_M-1:0] req, input int unsigned last, input int unsigned n);
    logic [MAX_M-1:0] g;
    int unsigned j;
    g = '0;
    for (int unsigned i = 1; i <= n; i++) begin
      j = last + i;
      j = j >= n ? j - n : j;
      if (g == '0 && req[3'(j)]) g[3'(j)] = 1'b1;
    end
    return g;
  endfunction
endpackage

// File: rtl/hram_arb_wdog.sv
// hram_arb_wdog: saturating stall counter; expired flags the stall cycle that completes TIMEOUT.
module hram_arb_wdog import hram_arb_pkg::*; #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clear ? '0 : (start && cnt_q != CW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
    expired = start & ~clear & (cnt_q >= CW'(TIMEOUT - 1));
  end
  always_ff @(posedge clk) cnt_q <= !resetn ? '0 : cnt_d;
endmodule

// File: rtl/hram_wb_arbiter.sv
// hram_wb_arbiter: round-robin Wishbone arbiter sharing one wb_hyperram port, holding grant per cyc.
module hram_wb_arbiter import hram_arb_pkg::*; #(
  parameter int NUM_M = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255,
  localparam int SW = DW / 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_M-1:0]   m_cyc_i,
  input  logic [NUM_M-1:0]   m_stb_i,
  input  logic [NUM_M-1:0]   m_we_i,
  input  logic [NUM_M*SW-1:0] m_sel_i,
  input  logic [NUM_M*AW-1:0] m_adr_i,
  input  logic [NUM_M*DW-1:0] m_dat_i,
  output logic [NUM_M*DW-1:0] m_dat_o,
  output logic [NUM_M-1:0]   m_ack_o,
  output logic [NUM_M-1:0]   m_err_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [SW-1:0]      s_sel_o,
  output logic [AW-1:0]      s_adr_o,
  output logic [DW-1:0]      s_dat_o,
  input  logic [DW-1:0]      s_dat_i,
  input  logic               s_ack_i,
  output logic [NUM_M-1:0]   grant_o,
  output logic               timeout_o
);
  localparam int LW = $clog2(NUM_M);
  state_t state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [LW-1:0] last_q, last_d, owner;
  logic own, owner_cyc, expired, wd_start;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= LW'(NUM_M - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
    end
  end
  always_comb begin
    owner = '0;
    for (int k = 0; k < NUM_M; k++) if (grant_q[k]) owner = LW'(k);
    owner_cyc = |(m_cyc_i & grant_q);
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    case (state_q)
      IDLE: if (|m_cyc_i) begin
        state_d = OWN;
        grant_d = NUM_M'(rr_pick(MAX_M'(m_cyc_i), 32'(last_q), NUM_M));
      end
      OWN: if (!owner_cyc) begin
        state_d = GAP;
        grant_d = '0;
        last_d = owner;
      end else if (expired) state_d = ABORT;
      ABORT: begin
        state_d = GAP;
        grant_d = '0;
        last_d = owner;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    own = state_q == OWN;
    s_cyc_o = own & owner_cyc;
    s_stb_o = own & |(m_cyc_i & m_stb_i & grant_q);
    s_we_o = own & |(m_we_i & grant_q);
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_dat_o = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (own && grant_q[k]) begin
        s_sel_o = m_sel_i[k*SW +: SW];
        s_adr_o = m_adr_i[k*AW +: AW];
        s_dat_o = m_dat_i[k*DW +: DW];
        m_dat_o[k*DW +: DW] = s_dat_i;
      end
    end
    m_ack_o = own ? grant_q & {NUM_M{s_ack_i}} : '0;
    m_err_o = state_q == ABORT ? grant_q : '0;
    timeout_o = state_q == ABORT;
  end
  assign grant_o = grant_q;
  // Ack in the same cycle keeps the counter from firing.
  assign wd_start = s_stb_o & ~s_ack_i;
  hram_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk), .resetn(resetn), .start(wd_start), .clear(~wd_start), .expired(expired)
  );
endmodule

// File: tb/tb_hram_wb_arbiter.sv
// tb_hram_wb_arbiter: directed scenarios with a tenure-level reference model checked every cycle.
module tb_hram_wb_arbiter;
  localparam int N = 2, AW = 32, DW = 32, SW = 4, TO = 16;
  logic clk = 0, resetn = 0;
  always #5 clk = ~clk;
  logic [N-1:0] m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
  logic [N*SW-1:0] m_sel_i = '0;
  logic [N*AW-1:0] m_adr_i = '0;
  logic [N*DW-1:0] m_dat_i = '0;
  logic [N*DW-1:0] m_dat_o;
  logic [N-1:0] m_ack_o, m_err_o, grant_o;
  logic s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [SW-1:0] s_sel_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [DW-1:0] s_dat_i = '0;
  logic s_ack_i = 0;

  hram_wb_arbiter #(.NUM_M(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  int checks = 0, errors = 0, cyc_n = 0, lat = 1;
  bit mon_en = 0;
  int glog[$];
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Slave: acks lat cycles after stb first seen; lat==0 never acks.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      cnt = (s_stb_o && !s_ack_i) ? cnt + 1 : 0;
      #1;
      s_ack_i = lat > 0 && cnt == lat;
      s_dat_i = s_ack_i ? 32'hDEADBEEF : '0;
    end
  end

  // Reference model: who owns the port, whether it is aborting or in the idle gap.
  int m_owner = -1, m_stall = 0, m_last = N - 1;
  bit m_abort = 0, m_gap = 0;
  logic [N-1:0] prev_g = '0;
  always @(negedge clk) begin : model
    logic [N-1:0] e_grant, e_ack, e_err;
    logic e_cyc, e_stb, e_we, live;
    logic [SW-1:0] e_sel;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [N*DW-1:0] e_rd;
    if (mon_en) begin
      live = m_owner >= 0 && !m_abort;
      e_grant = m_owner >= 0 ? N'(1) << m_owner : '0;
      {e_cyc, e_stb, e_we, e_sel, e_adr, e_dat, e_rd, e_ack} = '0;
      if (live) begin
        e_cyc = m_cyc_i[m_owner];
        e_stb = m_cyc_i[m_owner] & m_stb_i[m_owner];
        e_we = m_we_i[m_owner];
        e_sel = m_sel_i[m_owner*SW +: SW];
        e_adr = m_adr_i[m_owner*AW +: AW];
        e_dat = m_dat_i[m_owner*DW +: DW];
        e_rd[m_owner*DW +: DW] = s_dat_i;
        e_ack = s_ack_i ? e_grant : '0;
      end
      e_err = m_abort ? e_grant : '0;
      chk("grant", 64'(grant_o), 64'(e_grant));
      chk("s_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 64'({e_cyc, e_stb, e_we, e_sel}));
      chk("s_adr", 64'(s_adr_o), 64'(e_adr));
      chk("s_dat", 64'(s_dat_o), 64'(e_dat));
      chk("m_dat", 64'(m_dat_o), 64'(e_rd));
      chk("m_ack", 64'(m_ack_o), 64'(e_ack));
      chk("m_err", 64'(m_err_o), 64'(e_err));
      chk("timeout", 64'(timeout_o), 64'(m_abort));
      if (grant_o != '0 && prev_g == '0) glog.push_back(int'(grant_o));
      prev_g = grant_o;
      if (!resetn) begin
        m_owner = -1; m_abort = 0; m_gap = 0; m_stall = 0; m_last = N - 1;
      end else if (m_abort) begin
        m_last = m_owner; m_owner = -1; m_abort = 0; m_gap = 1; m_stall = 0;
      end else if (m_gap) m_gap = 0;
      else if (m_owner < 0) begin
        for (int i = 1; i <= N; i++) if (m_owner < 0 && m_cyc_i[(m_last + i) % N]) m_owner = (m_last + i) % N;
      end else if (!m_cyc_i[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_gap = 1; m_stall = 0;
      end else if (e_stb && !s_ack_i) begin
        m_stall++;
        if (m_stall >= TO) begin
          m_abort = 1; m_stall = 0;
        end
      end else m_stall = 0;
    end
  end

  // One single-beat access; records request, first-grant and ack/err cycles.
  task automatic xfer(input int k, input bit we, input logic [31:0] adr, input logic [31:0] wd, input bit keep,
                      output int t_req, output int t_gnt, output int t_end, output logic [63:0] rd,
                      output bit got_err, output logic [1:0] fl);
    bit done;
    @(posedge clk); #1;
    m_cyc_i[k] = 1; m_stb_i[k] = 1; m_we_i[k] = we;
    m_adr_i[k*AW +: AW] = adr; m_dat_i[k*DW +: DW] = wd; m_sel_i[k*SW +: SW] = '1;
    t_req = cyc_n; t_gnt = -1; t_end = -1; rd = '0; got_err = 0; fl = '0; done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (t_gnt < 0 && grant_o[k]) t_gnt = cyc_n;
      if (m_ack_o[k] || m_err_o[k]) begin
        got_err = m_err_o[k]; rd = m_dat_o; t_end = cyc_n; fl = {timeout_o, s_cyc_o}; done = 1;
      end
    end
    chk("xfer_done", 64'(done), 64'(1));
    @(posedge clk); #1;
    m_stb_i[k] = 0; m_cyc_i[k] = keep;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int r0, g0, e0, r1, g1, e1, r2, g2, e2, bad, n0;
    logic [63:0] d0, d1, d2;
    bit er0, er1, er2;
    logic [1:0] f0, f1, f2;
    @(posedge clk); #1 mon_en = 1;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk("reset_outs", 64'({grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, timeout_o}), 64'(0));

    // Single master read, 12-cycle slave.
    lat = 12;
    xfer(0, 0, 32'h3000_0010, 0, 0, r0, g0, e0, d0, er0, f0);
    chk("single_gnt_lat", 64'(g0 - r0), 64'(1));
    chk("single_ack_lat", 64'(e0 - g0), 64'(12));
    chk("single_rdata", d0, 64'h0000_0000_DEAD_BEEF);
    chk("single_err", 64'(er0), 64'(0));

    // Simultaneous requests after reset: M0 first, M1 three cycles after M0 drops cyc.
    do_reset();
    lat = 2;
    fork
      xfer(0, 0, 32'h100, 0, 0, r0, g0, e0, d0, er0, f0);
      xfer(1, 0, 32'h200, 0, 0, r1, g1, e1, d1, er1, f1);
    join
    chk("simul_same_req", 64'(r1 - r0), 64'(0));
    chk("simul_m0_first", 64'(g0 - r0), 64'(1));
    chk("simul_m1_after", 64'(g1 - (e0 + 1)), 64'(3));
    chk("simul_m1_rdata", d1, 64'hDEAD_BEEF_0000_0000);

    // Continuous contention: strict alternation, ten tenures each.
    lat = 1;
    repeat (3) @(posedge clk);
    glog.delete();
    fork
      for (int j = 0; j < 10; j++) xfer(0, 1, 32'h1000 + j, 32'hA000 + j, 0, r0, g0, e0, d0, er0, f0);
      for (int j = 0; j < 10; j++) xfer(1, 0, 32'h2000 + j, 0, 0, r1, g1, e1, d1, er1, f1);
    join
    bad = 0; n0 = 0;
    foreach (glog[i]) begin
      if (glog[i] != (i % 2 == 0 ? 1 : 2)) bad++;
      if (glog[i] == 1) n0++;
    end
    chk("cont_tenures", 64'(glog.size()), 64'(20));
    chk("cont_alternate", 64'(bad), 64'(0));
    chk("cont_m0_count", 64'(n0), 64'(10));

    // Atomic tenure: read then write under one cyc while M1 waits.
    lat = 2;
    repeat (3) @(posedge clk);
    glog.delete();
    fork
      begin
        xfer(0, 0, 32'h3000, 0, 1, r0, g0, e0, d0, er0, f0);
        xfer(0, 1, 32'h3000, 32'h5555_AAAA, 0, r2, g2, e2, d2, er2, f2);
      end
      begin
        repeat (2) @(posedge clk);
        xfer(1, 0, 32'h4000, 0, 0, r1, g1, e1, d1, er1, f1);
      end
    join
    chk("atomic_tenures", 64'(glog.size()), 64'(2));
    chk("atomic_second_held", 64'(g2 - r2), 64'(0));
    chk("atomic_m1_after", 64'(g1 - (e2 + 1)), 64'(3));
    chk("atomic_write_ok", 64'({er2, f2}), 64'(3'b001));

    // Timeout: slave never acks M0; err 16 cycles after stb, then M1 served.
    repeat (3) @(posedge clk);
    lat = 0;
    fork
      begin
        xfer(0, 0, 32'h5000, 0, 0, r0, g0, e0, d0, er0, f0);
        lat = 3;
      end
      begin
        @(posedge clk);
        xfer(1, 0, 32'h6000, 0, 0, r1, g1, e1, d1, er1, f1);
      end
    join
    chk("to_err", 64'(er0), 64'(1));
    chk("to_delay", 64'(e0 - g0), 64'(16));
    chk("to_flags", 64'(f0), 64'(2'b10));
    chk("to_m1_next", 64'(g1 - e0), 64'(3));
    chk("to_m1_ok", 64'(er1), 64'(0));

    // Reset in the middle of an M1 tenure.
    repeat (3) @(posedge clk);
    #1 lat = 0; m_cyc_i[1] = 1; m_stb_i[1] = 1; m_adr_i[AW +: AW] = 32'h7000;
    for (int i = 0; i < 10 && grant_o != 2'b10; i++) @(negedge clk);
    chk("rst_pre_grant", 64'(grant_o), 64'(2'b10));
    repeat (3) @(posedge clk);
    #1 resetn = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", 64'({grant_o, s_cyc_o, s_stb_o, s_we_o, m_ack_o, m_err_o, timeout_o}), 64'(0));
    chk("rst_bus", 64'({s_adr_o, s_sel_o}), 64'(0));
    chk("rst_mdat", 64'(m_dat_o), 64'(0));
    m_cyc_i = '0; m_stb_i = '0; lat = 2;
    @(posedge clk); #1 resetn = 1;
    fork
      xfer(0, 0, 32'h8000, 0, 0, r0, g0, e0, d0, er0, f0);
      xfer(1, 0, 32'h9000, 0, 0, r1, g1, e1, d1, er1, f1);
    join
    chk("rst_m0_first", 64'(g0 - r0), 64'(1));
    chk("rst_m1_second", 64'(g1 - (e0 + 1)), 64'(3));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
